// File: rtl/shape_calc_engine.sv
`default_nettype none
// ============================================================================
//  Module   : shape_calc_engine (with package shape_processor_modeling)
//  Purpose  : Sequential perimeter / area / shape-class engine behind the
//             CTRL SFR. Multiplies run on a one-bit-per-cycle shift-add
//             datapath; results are returned through a start/busy/done
//             handshake with illegal or degenerate requests flagged on error.
//  Revision : 1.0 - initial release
// ============================================================================

package shape_processor_modeling;

    // Shape field of CTRL; codes 4..7 are reserved.
    typedef enum logic [2:0] {
        KEEP_SHAPE = 3'd0,
        CIRCLE     = 3'd1,
        RECTANGLE  = 3'd2,
        TRIANGLE   = 3'd3
    } shape_e;

    // Operation field of CTRL; codes 6..7 are reserved.
    typedef enum logic [2:0] {
        KEEP_OPERATION = 3'd0,
        PERIMETER      = 3'd1,
        AREA           = 3'd2,
        IS_SQUARE      = 3'd3,
        IS_EQUILATERAL = 3'd4,
        IS_ISOSCELES   = 3'd5
    } operation_e;

    // Which operations make sense for which shape. KEEP_* and reserved
    // codes never form a legal pair.
    function automatic logic is_legal_combination(shape_e s, operation_e o);
        logic legal;
        legal = 1'b0;
        case (s)
            CIRCLE:    legal = (o == PERIMETER) || (o == AREA);
            RECTANGLE: legal = (o == PERIMETER) || (o == AREA) || (o == IS_SQUARE);
            TRIANGLE:  legal = (o == PERIMETER) || (o == IS_EQUILATERAL) ||
                               (o == IS_ISOSCELES);
            default:   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

module shape_calc_engine
    import shape_processor_modeling::*;
#(
    parameter int OPERAND_W = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  shape_e                    shape,
    input  operation_e                operation,
    input  logic [OPERAND_W-1:0]      side_a,
    input  logic [OPERAND_W-1:0]      side_b,
    input  logic [OPERAND_W-1:0]      side_c,
    output logic                      busy,
    output logic                      done,
    output logic [2*OPERAND_W+9:0]    result,
    output logic                      error
);

    localparam int RESULT_W = 2*OPERAND_W+10;
    localparam int CNT_W    = $clog2(OPERAND_W+1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPERAND_W-1);
    // pi and 2*pi in Q.8, truncated (804.25 -> 804, 1608.5 -> 1608)
    localparam logic [OPERAND_W-1:0] PI_Q8     = OPERAND_W'(804);
    localparam logic [OPERAND_W-1:0] TWO_PI_Q8 = OPERAND_W'(1608);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL1  = 3'd2,
        MUL2  = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e                 state;
    shape_e                 cap_shape;
    operation_e             cap_op;
    logic [OPERAND_W-1:0]   cap_a;
    logic [OPERAND_W-1:0]   cap_b;
    logic [OPERAND_W-1:0]   cap_c;
    logic [RESULT_W-1:0]    acc;
    logic [RESULT_W-1:0]    mcand;
    logic [OPERAND_W-1:0]   mplier;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   stage_err;

    // Operand sums, one bit wider so they never wrap
    logic [OPERAND_W:0]     sum_ab;
    logic [OPERAND_W:0]     sum_ac;
    logic [OPERAND_W:0]     sum_bc;
    logic [OPERAND_W+1:0]   sum_abc;

    assign sum_ab  = {1'b0, cap_a} + {1'b0, cap_b};
    assign sum_ac  = {1'b0, cap_a} + {1'b0, cap_c};
    assign sum_bc  = {1'b0, cap_b} + {1'b0, cap_c};
    assign sum_abc = {1'b0, sum_ab} + {2'b00, cap_c};

    // One shift-add step: add the multiplicand when the current multiplier bit is set
    logic [RESULT_W-1:0]    acc_step;
    logic                   mul_last;

    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (bit_cnt == CNT_LAST);

    logic                   req_error;
    logic [RESULT_W-1:0]    simple_result;
    logic                   tri_ok;

    // Request validation and the single-cycle results (adds and compares)
    always_comb begin
        req_error     = 1'b0;
        simple_result = '0;
        tri_ok        = ({1'b0, cap_a} < sum_bc) && ({1'b0, cap_b} < sum_ac) &&
                        ({1'b0, cap_c} < sum_ab);

        if (!is_legal_combination(cap_shape, cap_op)) begin
            req_error = 1'b1;
        end

        case (cap_shape)
            CIRCLE: begin
                if (cap_a == '0) req_error = 1'b1;
            end
            RECTANGLE: begin
                if ((cap_a == '0) || (cap_b == '0)) req_error = 1'b1;
            end
            TRIANGLE: begin
                if ((cap_a == '0) || (cap_b == '0) || (cap_c == '0) || !tri_ok) begin
                    req_error = 1'b1;
                end
            end
            default: req_error = 1'b1;
        endcase

        case (cap_op)
            PERIMETER: begin
                if (cap_shape == RECTANGLE) begin
                    simple_result = RESULT_W'(sum_ab) << 9;
                end else begin
                    simple_result = RESULT_W'(sum_abc) << 8;
                end
            end
            IS_SQUARE:      simple_result = RESULT_W'(cap_a == cap_b);
            IS_EQUILATERAL: simple_result = RESULT_W'((cap_a == cap_b) && (cap_b == cap_c));
            IS_ISOSCELES:   simple_result = RESULT_W'((cap_a == cap_b) || (cap_b == cap_c) ||
                                                      (cap_a == cap_c));
            default:        simple_result = '0;
        endcase
    end

    // Control FSM with capture registers, multiply datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cap_shape <= KEEP_SHAPE;
            cap_op    <= KEEP_OPERATION;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_c     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            bit_cnt   <= '0;
            stage_err <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_shape <= shape;
                        cap_op    <= operation;
                        cap_a     <= side_a;
                        cap_b     <= side_b;
                        cap_c     <= side_c;
                        state     <= CHECK;
                    end
                end

                CHECK: begin
                    busy      <= 1'b1;
                    bit_cnt   <= '0;
                    stage_err <= req_error;
                    acc       <= '0;
                    if (req_error) begin
                        state <= DONE;
                    end else if (cap_op == AREA && cap_shape == RECTANGLE) begin
                        mcand  <= RESULT_W'(cap_a);
                        mplier <= cap_b;
                        state  <= MUL1;
                    end else if (cap_op == PERIMETER && cap_shape == CIRCLE) begin
                        mcand  <= RESULT_W'(cap_a);
                        mplier <= TWO_PI_Q8;
                        state  <= MUL1;
                    end else if (cap_op == AREA && cap_shape == CIRCLE) begin
                        mcand  <= RESULT_W'(cap_a);
                        mplier <= cap_a;
                        state  <= MUL1;
                    end else begin
                        acc   <= simple_result;
                        state <= DONE;
                    end
                end

                MUL1: begin
                    acc     <= acc_step;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (mul_last) begin
                        bit_cnt <= '0;
                        if (cap_shape == CIRCLE && cap_op == AREA) begin
                            // r^2 becomes the multiplicand for the pi pass
                            mcand  <= acc_step;
                            mplier <= PI_Q8;
                            acc    <= '0;
                            state  <= MUL2;
                        end else if (cap_shape == RECTANGLE) begin
                            // integer a*b promoted to Q.8
                            acc   <= acc_step << 8;
                            state <= DONE;
                        end else begin
                            // 2*pi constant is already Q.8
                            state <= DONE;
                        end
                    end
                end

                MUL2: begin
                    acc     <= acc_step;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (mul_last) begin
                        bit_cnt <= '0;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    result <= acc;
                    error  <= stage_err;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shape_calc_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shape_calc_engine
//  Purpose  : Directed self-checking bench for shape_calc_engine
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shape_calc_engine;
    import shape_processor_modeling::*;

    localparam int OPERAND_W = 12;
    localparam int RESULT_W  = 2*OPERAND_W+10;

    logic                  clk;
    logic                  rst;
    logic                  start;
    shape_e                shape;
    operation_e            operation;
    logic [OPERAND_W-1:0]  side_a;
    logic [OPERAND_W-1:0]  side_b;
    logic [OPERAND_W-1:0]  side_c;
    logic                  busy;
    logic                  done;
    logic [RESULT_W-1:0]   result;
    logic                  error;

    int vectors;
    int miscompares;

    shape_calc_engine #(.OPERAND_W(OPERAND_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shape     (shape),
        .operation (operation),
        .side_a    (side_a),
        .side_b    (side_b),
        .side_c    (side_c),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request; start is sampled at edge 0, cycle n is observed on the
    // falling edge after edge n. Optionally pokes new start/modes at poke_cyc.
    task automatic run_op(input string tag, input shape_e s, input operation_e o,
                          input int a, input int b, input int c,
                          input int exp_cyc, input logic [63:0] exp_res,
                          input logic exp_err, input int poke_cyc);
        int  cyc;
        int  busy_cnt;
        bit  got;
        @(negedge clk);
        start     = 1'b1;
        shape     = s;
        operation = o;
        side_a    = OPERAND_W'(a);
        side_b    = OPERAND_W'(b);
        side_c    = OPERAND_W'(c);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy@0"}, 64'(busy), 64'd0);
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1'b1;
            end else if (busy) begin
                busy_cnt++;
            end
            if (!got && cyc == poke_cyc) begin
                start     = 1'b1;
                shape     = CIRCLE;
                operation = AREA;
                side_a    = OPERAND_W'(9);
                side_b    = OPERAND_W'(9);
                side_c    = OPERAND_W'(9);
            end
            if (cyc == poke_cyc + 1) start = 1'b0;
        end
        start = 1'b0;
        chk({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " result"}, 64'(result), exp_res);
        chk({tag, " error"}, 64'(error), 64'(exp_err));
        chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_cyc - 1));
        chk({tag, " busy at done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dcount;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        start     = 1'b0;
        shape     = KEEP_SHAPE;
        operation = KEEP_OPERATION;
        side_a    = '0;
        side_b    = '0;
        side_c    = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset busy",   64'(busy),   64'd0);
        chk("reset done",   64'(done),   64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset error",  64'(error),  64'd0);
        rst = 1'b0;

        // Multiply paths
        run_op("rect_area_3x5",  RECTANGLE, AREA, 3, 5, 0, 14, 64'd3840, 1'b0, -1);
        run_op("circ_area_2",    CIRCLE, AREA, 2, 0, 0, 26, 64'd3216, 1'b0, -1);
        run_op("circ_perim_1",   CIRCLE, PERIMETER, 1, 0, 0, 14, 64'd1608, 1'b0, -1);
        run_op("rect_area_max",  RECTANGLE, AREA, 4095, 4095, 0, 14, 64'd4292870400, 1'b0, -1);
        run_op("circ_area_max",  CIRCLE, AREA, 4095, 0, 0, 26, 64'd13482296100, 1'b0, -1);

        // Single-cycle results
        run_op("rect_perim_3_5", RECTANGLE, PERIMETER, 3, 5, 0, 2, 64'd4096, 1'b0, -1);
        run_op("tri_perim_345",  TRIANGLE, PERIMETER, 3, 4, 5, 2, 64'd3072, 1'b0, -1);
        run_op("tri_iso_558",    TRIANGLE, IS_ISOSCELES, 5, 5, 8, 2, 64'd1, 1'b0, -1);
        run_op("tri_iso_345",    TRIANGLE, IS_ISOSCELES, 3, 4, 5, 2, 64'd0, 1'b0, -1);
        run_op("tri_equi_444",   TRIANGLE, IS_EQUILATERAL, 4, 4, 4, 2, 64'd1, 1'b0, -1);
        run_op("tri_iso_equi",   TRIANGLE, IS_ISOSCELES, 4, 4, 4, 2, 64'd1, 1'b0, -1);
        run_op("rect_sq_66",     RECTANGLE, IS_SQUARE, 6, 6, 0, 2, 64'd1, 1'b0, -1);
        run_op("rect_sq_67",     RECTANGLE, IS_SQUARE, 6, 7, 0, 2, 64'd0, 1'b0, -1);

        // Rejected requests
        run_op("tri_degenerate", TRIANGLE, IS_ISOSCELES, 1, 2, 3, 2, 64'd0, 1'b1, -1);
        run_op("circ_is_square", CIRCLE, IS_SQUARE, 7, 7, 7, 2, 64'd0, 1'b1, -1);
        run_op("rect_perim_b0",  RECTANGLE, PERIMETER, 7, 0, 0, 2, 64'd0, 1'b1, -1);
        run_op("circ_perim_a0",  CIRCLE, PERIMETER, 0, 0, 0, 2, 64'd0, 1'b1, -1);
        run_op("tri_area",       TRIANGLE, AREA, 3, 4, 5, 2, 64'd0, 1'b1, -1);
        run_op("keep_shape",     KEEP_SHAPE, AREA, 3, 4, 5, 2, 64'd0, 1'b1, -1);
        run_op("reserved_shape", shape_e'(3'd5), AREA, 3, 4, 5, 2, 64'd0, 1'b1, -1);
        run_op("reserved_op",    RECTANGLE, operation_e'(3'd6), 3, 4, 0, 2, 64'd0, 1'b1, -1);
        run_op("tri_ineq_big_c", TRIANGLE, PERIMETER, 2, 3, 9, 2, 64'd0, 1'b1, -1);

        // Start and mode changes while busy are ignored, nothing is queued
        run_op("busy_poke", RECTANGLE, AREA, 3, 5, 0, 14, 64'd3840, 1'b0, 5);
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("busy_poke no extra done", 64'(dcount), 64'd0);
        chk("busy_poke result held",   64'(result), 64'd3840);

        // Asynchronous reset mid-multiply aborts the request
        @(negedge clk);
        start     = 1'b1;
        shape     = RECTANGLE;
        operation = AREA;
        side_a    = OPERAND_W'(3);
        side_b    = OPERAND_W'(5);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort busy before rst", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort busy",   64'(busy),   64'd0);
        chk("abort result", 64'(result), 64'd0);
        chk("abort error",  64'(error),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort no done", 64'(dcount), 64'd0);
        run_op("after_abort", RECTANGLE, AREA, 6, 7, 0, 14, 64'd10752, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
